// File: rtl/t_flip_flop.sv
// -----------------------------------------------------------------------------
// t_flip_flop
//   Bank of WIDTH independent toggle (T) flip-flops sharing one clock.
//   On every rising clk edge, each bit of data_out inverts where the matching
//   data bit is 1 and holds where it is 0. There is no carry or other
//   interaction between bits, so the cell can be used as a leaf for counters,
//   clock dividers and parity/state toggles.
//
// Parameters
//   WIDTH      number of independent toggle bits (>= 1)
//   RESET_VAL  value forced onto data_out while reset is asserted
//
// Ports
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-low reset (0 = asserted)
//   data      in   WIDTH  per-bit toggle enable (T input)
//   data_out  out  WIDTH  registered state (Q)
//
// Notes
//   - Reset asserts and releases asynchronously; after release, data_out keeps
//     RESET_VAL until the first rising edge that sees reset high.
//   - data_out is driven straight from the state register, so there is no
//     combinational path from data to data_out.
// -----------------------------------------------------------------------------
module t_flip_flop #(
  parameter int unsigned            WIDTH     = 1,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] state_r;
  logic [WIDTH-1:0] next_s;

  // Next state: XOR inverts exactly the bits whose toggle enable is set.
  always_comb begin
    next_s = state_r;
    if (reset) begin
      next_s = state_r ^ data;
    end else begin
      next_s = RESET_VAL;
    end
  end

  // State register with asynchronous active-low reset; reset dominates any
  // coincident clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= RESET_VAL;
    end else begin
      state_r <= next_s;
    end
  end

  assign data_out = state_r;

endmodule

// File: tb/tb_t_flip_flop.sv
module tb_t_flip_flop;

  logic       clk;
  logic       reset_a;
  logic [0:0] data_a;
  logic [0:0] out_a;
  logic       reset_b;
  logic [3:0] data_b;
  logic [3:0] out_b;

  logic [0:0] model_a;
  logic [3:0] model_b;
  logic       armed;

  int n_checks;
  int n_errors;

  // Default configuration: single-bit T flip-flop, reset value 0.
  t_flip_flop u_dut_a (
    .clk      (clk),
    .reset    (reset_a),
    .data     (data_a),
    .data_out (out_a)
  );

  // Wide configuration with a non-zero reset value.
  t_flip_flop #(.WIDTH(4), .RESET_VAL(4'b0011)) u_dut_b (
    .clk      (clk),
    .reset    (reset_b),
    .data     (data_b),
    .data_out (out_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference models, asynchronous active-low reset like the real thing.
  always @(posedge clk or negedge reset_a) begin
    if (!reset_a) model_a <= 1'b0;
    else          model_a <= model_a ^ data_a;
  end

  always @(posedge clk or negedge reset_b) begin
    if (!reset_b) model_b <= 4'b0011;
    else          model_b <= model_b ^ data_b;
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s t=%0t clk=%b reset_a=%b reset_b=%b data_a=%b data_b=%b out_a=%b out_b=%b observed=%b expected=%b",
             tag, $time, clk, reset_a, reset_b, data_a, data_b, out_a, out_b, obs, exp);
    end
  endtask

  // Continuous comparison against the reference models shortly after each edge.
  always @(posedge clk) begin
    #2;
    if (armed) begin
      check("model_a", {3'b000, out_a}, {3'b000, model_a});
      check("model_b", out_b, model_b);
    end
  end

  task automatic edge_then_check(input string tag, input logic [3:0] exp_a);
    @(posedge clk);
    #1;
    check(tag, {3'b000, out_a}, exp_a);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    armed    = 1'b0;
    reset_a  = 1'b1;
    reset_b  = 1'b1;
    data_a   = 1'b0;
    data_b   = 4'b0000;

    // Power-up reset: a real falling edge on both resets.
    #1;
    reset_a = 1'b0;
    reset_b = 1'b0;
    #1;
    armed = 1'b1;
    check("rst_a_async", {3'b000, out_a}, 4'b0000);
    check("rst_b_async", out_b, 4'b0011);

    // 1: reset held low, clock running, data toggling -> output stays reset.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data_a = ~data_a;
      data_b = ~data_b;
      edge_then_check("rst_hold_a", 4'b0000);
      check("rst_hold_b", out_b, 4'b0011);
    end

    // 2: release, data=1 for 4 edges -> 1,0,1,0.
    @(negedge clk);
    reset_a = 1'b1;
    data_a  = 1'b1;
    #1;
    check("release_no_edge", {3'b000, out_a}, 4'b0000);
    edge_then_check("toggle_e1", 4'b0001);
    edge_then_check("toggle_e2", 4'b0000);
    edge_then_check("toggle_e3", 4'b0001);
    edge_then_check("toggle_e4", 4'b0000);

    // 3: reach 1, then data=0 for 3 edges -> hold 1.
    edge_then_check("toggle_e5", 4'b0001);
    @(negedge clk);
    data_a = 1'b0;
    edge_then_check("hold_e1", 4'b0001);
    edge_then_check("hold_e2", 4'b0001);
    edge_then_check("hold_e3", 4'b0001);

    // 4: assert reset between edges -> 0 at once, stays 0 despite toggles.
    @(negedge clk);
    reset_a = 1'b0;
    #1;
    check("mid_rst_async", {3'b000, out_a}, 4'b0000);
    data_a = 1'b1;
    edge_then_check("mid_rst_e1", 4'b0000);
    edge_then_check("mid_rst_e2", 4'b0000);

    // 5: release mid-cycle with data=1 -> 0 until next edge, then 1.
    @(negedge clk);
    #2;
    reset_a = 1'b1;
    #1;
    check("rel_mid_a", {3'b000, out_a}, 4'b0000);
    #1;
    check("rel_mid_b", {3'b000, out_a}, 4'b0000);
    edge_then_check("rel_first_edge", 4'b0001);

    // Reset coinciding with a clock edge wins (data=0 so a lost reset shows as 1).
    @(negedge clk);
    data_a = 1'b0;
    @(posedge clk);
    reset_a = 1'b0;
    #1;
    check("rst_vs_edge", {3'b000, out_a}, 4'b0000);

    // 6: WIDTH=4, RESET_VAL=0011; bits toggle independently.
    @(negedge clk);
    check("wide_rst", out_b, 4'b0011);
    reset_b = 1'b1;
    data_b  = 4'b1010;
    @(posedge clk);
    #1;
    check("wide_1010", out_b, 4'b1001);
    @(negedge clk);
    data_b = 4'b1111;
    @(posedge clk);
    #1;
    check("wide_1111", out_b, 4'b0110);
    @(negedge clk);
    data_b = 4'b0000;
    @(posedge clk);
    #1;
    check("wide_hold1", out_b, 4'b0110);
    @(posedge clk);
    #1;
    check("wide_hold2", out_b, 4'b0110);
    @(negedge clk);
    data_b = 4'b0100;
    @(posedge clk);
    #1;
    check("wide_0100", out_b, 4'b0010);

    @(posedge clk);
    #4;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
